// File: rtl/pll_reset_seq.sv
// Reset sequencer: debounces the synchronised PLL lock, then releases the memory reset, then the system reset.
// Define PLL_RESET_SEQ_RELOCK_EN to build in the lock watchdog and the pll_reinit pulse.
module pll_reset_seq #(
    parameter int STABLE_CYCLES     = 1024,
    parameter int MEM_TO_SYS_CYCLES = 256,
    parameter int LOCK_TIMEOUT      = 50000,
    parameter int REINIT_PULSE      = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    output logic       mem_resetn,
    output logic       sys_resetn,
    output logic       ready,
    output logic [7:0] lost_cnt,
    output logic       pll_reinit,
    output logic [2:0] state_dbg
);

    localparam logic [19:0] STABLE_LOAD = 20'(STABLE_CYCLES - 1);
    localparam logic [19:0] M2S_LOAD    = 20'(MEM_TO_SYS_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 1 || STABLE_CYCLES > (1 << 20) ||
            MEM_TO_SYS_CYCLES < 1 || MEM_TO_SYS_CYCLES > (1 << 20) ||
            LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > (1 << 20) ||
            REINIT_PULSE < 1 || REINIT_PULSE > (1 << 20)) begin : g_bad_params
            $error("pll_reset_seq: parameter out of range 1..2^20");
        end
    endgenerate

`ifdef PLL_RESET_SEQ_RELOCK_EN
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        REL_MEM   = 3'd2,
        RUN       = 3'd3,
        REINIT    = 3'd4
    } state_t;

    localparam logic [19:0] TMO_LAST    = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] PULSE_LOAD  = 20'(REINIT_PULSE - 1);

    logic [19:0] tmo_cnt;
`else
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        REL_MEM   = 3'd2,
        RUN       = 3'd3
    } state_t;
`endif

    state_t      state;
    logic [19:0] cnt;
    logic        lock_m;
    logic        lock_s;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_m     <= 1'b0;
            lock_s     <= 1'b0;
            state      <= WAIT_LOCK;
            cnt        <= '0;
            mem_resetn <= 1'b0;
            sys_resetn <= 1'b0;
            ready      <= 1'b0;
            lost_cnt   <= '0;
`ifdef PLL_RESET_SEQ_RELOCK_EN
            tmo_cnt    <= '0;
            pll_reinit <= 1'b0;
`endif
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        cnt   <= STABLE_LOAD;
                        state <= STABLE;
`ifdef PLL_RESET_SEQ_RELOCK_EN
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt    <= '0;
                        cnt        <= PULSE_LOAD;
                        pll_reinit <= 1'b1;
                        state      <= REINIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
`endif
                    end
                end
                // Lock loss is tested before counter expiry so it always wins.
                STABLE: begin
                    if (!lock_s) begin
                        cnt   <= '0;
                        state <= WAIT_LOCK;
                    end else if (cnt == '0) begin
                        mem_resetn <= 1'b1;
                        cnt        <= M2S_LOAD;
                        state      <= REL_MEM;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                REL_MEM: begin
                    if (!lock_s) begin
                        mem_resetn <= 1'b0;
                        cnt        <= '0;
                        state      <= WAIT_LOCK;
                    end else if (cnt == '0) begin
                        sys_resetn <= 1'b1;
                        ready      <= 1'b1;
                        state      <= RUN;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        mem_resetn <= 1'b0;
                        sys_resetn <= 1'b0;
                        ready      <= 1'b0;
                        cnt        <= '0;
                        state      <= WAIT_LOCK;
                        if (lost_cnt != 8'hFF) begin
                            lost_cnt <= lost_cnt + 8'd1;
                        end
                    end
                end
`ifdef PLL_RESET_SEQ_RELOCK_EN
                // Lock is deliberately ignored while the PLL is being re-initialised.
                REINIT: begin
                    if (cnt == '0) begin
                        pll_reinit <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= WAIT_LOCK;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
`endif
                default: begin
                    mem_resetn <= 1'b0;
                    sys_resetn <= 1'b0;
                    ready      <= 1'b0;
                    cnt        <= '0;
                    state      <= WAIT_LOCK;
                end
            endcase
        end
    end

`ifndef PLL_RESET_SEQ_RELOCK_EN
    assign pll_reinit = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed-plus-random bench for pll_reset_seq; expected outputs come from a lock run-length model.
module tb_pll_reset_seq;

    localparam int S     = 8;
    localparam int M     = 4;
    localparam int TMO   = 20;
    localparam int PULSE = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pll_lock = 1'b0;
    logic       mem_resetn;
    logic       sys_resetn;
    logic       ready;
    logic [7:0] lost_cnt;
    logic       pll_reinit;
    logic [2:0] state_dbg;

    pll_reset_seq #(
        .STABLE_CYCLES    (S),
        .MEM_TO_SYS_CYCLES(M),
        .LOCK_TIMEOUT     (TMO),
        .REINIT_PULSE     (PULSE)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pll_lock  (pll_lock),
        .mem_resetn(mem_resetn),
        .sys_resetn(sys_resetn),
        .ready     (ready),
        .lost_cnt  (lost_cnt),
        .pll_reinit(pll_reinit),
        .state_dbg (state_dbg)
    );

    always #10 clk = ~clk;

    // Reference model: a resynchronised lock history and the length of its current high run.
    int cyc = 0;
    bit m_s1 = 1'b0;
    bit m_ls = 1'b0;
    int m_run = 0;
    int m_lost = 0;
    bit e_mem = 1'b0;
    bit e_sys = 1'b0;
    bit e_reinit = 1'b0;
    bit wd_mode = 1'b0;
    int wd_base = 0;
    int n_vec = 0;
    int n_err = 0;

    task automatic expect_bit(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_cnt(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input bit pll, input bit rst);
        pll_lock = pll;
        resetn   = rst;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            m_s1 = 1'b0; m_ls = 1'b0; m_run = 0; m_lost = 0;
            e_mem = 1'b0; e_sys = 1'b0;
            wd_base = cyc;
        end else begin
            if (e_sys && !m_ls && m_lost < 255) m_lost++;
            m_run = m_ls ? m_run + 1 : 0;
            m_ls  = m_s1;
            m_s1  = pll;
            e_mem = (m_run >= S + 1);
            e_sys = (m_run >= S + 1 + M);
        end
        e_reinit = 1'b0;
`ifdef PLL_RESET_SEQ_RELOCK_EN
        if (wd_mode && cyc > wd_base) e_reinit = (((cyc - wd_base) % (TMO + PULSE)) >= TMO);
`endif
        #1;
        expect_bit("mem_resetn", mem_resetn, e_mem);
        expect_bit("sys_resetn", sys_resetn, e_sys);
        expect_bit("ready", ready, e_sys);
        expect_cnt("lost_cnt", lost_cnt, 8'(m_lost));
        expect_bit("pll_reinit", pll_reinit, e_reinit);
    endtask

    task automatic run_until_sys();
        int k = 0;
        while (!e_sys && k < 200) begin
            step(1'b1, 1'b1);
            k++;
        end
        expect_bit("reach_run", sys_resetn, 1'b1);
    endtask

    initial begin
        int t_rise;
        int g;
        int d;
        int r;
        int k;

        // Reset state
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        expect_bit("rst_mem", mem_resetn, 1'b0);
        expect_bit("rst_sys", sys_resetn, 1'b0);
        expect_bit("rst_ready", ready, 1'b0);
        expect_cnt("rst_lost", lost_cnt, 8'd0);
        expect_bit("rst_reinit", pll_reinit, 1'b0);

        // Clean lock: pll_lock rises in cycle 10
        while (cyc < 10) step(1'b0, 1'b1);
        t_rise = cyc;
        while (cyc < t_rise + 10) step(1'b1, 1'b1);
        expect_bit("clean_mem_early", mem_resetn, 1'b0);
        step(1'b1, 1'b1);
        expect_bit("clean_mem_21", mem_resetn, 1'b1);
        expect_bit("clean_sys_21", sys_resetn, 1'b0);
        while (cyc < 24) step(1'b1, 1'b1);
        expect_bit("clean_sys_early", sys_resetn, 1'b0);
        step(1'b1, 1'b1);
        expect_bit("clean_sys_25", sys_resetn, 1'b1);
        expect_bit("clean_ready_25", ready, 1'b1);
        expect_cnt("clean_lost", lost_cnt, 8'd0);

        // Loss in RUN followed by a one-cycle glitch during debounce
        repeat (3) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b1);
        g = cyc;
        step(1'b0, 1'b1);
        while (cyc < g + 11) step(1'b1, 1'b1);
        expect_bit("glitch_mem_held", mem_resetn, 1'b0);
        step(1'b1, 1'b1);
        expect_bit("glitch_mem_rel", mem_resetn, 1'b1);
        expect_cnt("glitch_lost", lost_cnt, 8'd1);
        run_until_sys();

        // Repeated lock loss in RUN, with occasional random debounce glitches
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) step(1'b1, 1'b1);
            d = cyc;
            step(1'b0, 1'b1);
            step(1'b0, 1'b1);
            expect_bit("loss_sys_before", sys_resetn, 1'b1);
            step(1'b0, 1'b1);
            expect_bit("loss_mem_drop", mem_resetn, 1'b0);
            expect_bit("loss_sys_drop", sys_resetn, 1'b0);
            if (i == 0) expect_cnt("loss_lost_first", lost_cnt, 8'd2);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 6)) step(1'b1, 1'b1);
                step(1'b0, 1'b1);
            end
            run_until_sys();
        end
        expect_cnt("loss_saturate", lost_cnt, 8'd255);

        // Reset pulse during REL_MEM
        k = 0;
        while (!(e_mem && !e_sys) && k < 200) begin
            step(1'b1, 1'b1);
            k++;
        end
        expect_bit("reach_rel_mem", mem_resetn, 1'b1);
        step(1'b1, 1'b0);
        r = cyc;
        expect_bit("midrst_mem", mem_resetn, 1'b0);
        expect_bit("midrst_sys", sys_resetn, 1'b0);
        expect_bit("midrst_ready", ready, 1'b0);
        expect_cnt("midrst_lost", lost_cnt, 8'd0);
        while (cyc < r + 10) step(1'b1, 1'b1);
        expect_bit("midrst_mem_early", mem_resetn, 1'b0);
        step(1'b1, 1'b1);
        expect_bit("midrst_mem_rel", mem_resetn, 1'b1);

        // Random lock waveform with occasional resets; low spans stay under the watchdog timeout
        for (int seg = 0; seg < 120; seg++) begin
            repeat ($urandom_range(1, 25)) step(1'b1, ($urandom_range(0, 59) != 0));
            repeat ($urandom_range(1, 10)) step(1'b0, ($urandom_range(0, 39) != 0));
        end

        // Watchdog with lock held low
        wd_mode = 1'b1;
        step(1'b0, 1'b0);
        for (int j = 1; j <= 60; j++) begin
            step(1'b0, 1'b1);
`ifdef PLL_RESET_SEQ_RELOCK_EN
            if (j == 19) expect_bit("wd_before", pll_reinit, 1'b0);
            if (j == 20) expect_bit("wd_pulse", pll_reinit, 1'b1);
            if (j == 24) expect_bit("wd_after", pll_reinit, 1'b0);
            if (j == 44) expect_bit("wd_repeat", pll_reinit, 1'b1);
`else
            if (j == 20) expect_bit("wd_tied", pll_reinit, 1'b0);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset sequencer downstream of the PLL wrapper, running on the 50 MHz init clock. Synchronises the raw PLL lock, requires it to stay high for a debounce window, then releases resets in order: memory controller first, then the CPU/system domain. Any lock loss re-asserts both resets at once and restarts the sequence. An optional watchdog pulses a PLL re-initialisation request when lock never arrives.

## Interface
Parameters:
- STABLE_CYCLES, 1024, consecutive synchronised-lock-high cycles required before memory reset release.
- MEM_TO_SYS_CYCLES, 256, cycles between mem_resetn and sys_resetn release.
- LOCK_TIMEOUT, 50000, cycles in WAIT_LOCK before a re-init request (1 ms at 50 MHz).
- REINIT_PULSE, 16, width of the pll_reinit pulse in cycles.
- Constraints: all parameters ≥ 1 and ≤ 2^20; one shared 20-bit down-counter.

Ports:
- clk  in  1  50 MHz init clock; sole clock.
- resetn  in  1  synchronous, active-low reset.
- pll_lock  in  1  raw PLL lock, asynchronous to clk.
- mem_resetn  out  1  active-low reset to the memory controller.
- sys_resetn  out  1  active-low reset to CPU/system logic.
- ready  out  1  high while in RUN.
- lost_cnt  out  8  saturating count of lock losses seen in RUN.
- pll_reinit  out  1  active-high PLL re-init request (RELOCK feature only).

## Operation
- pll_lock goes through a 2-flop synchroniser (lock_s); all decisions use lock_s.
- States:
  - WAIT_LOCK: load counter = STABLE_CYCLES-1 when lock_s=1, then go to STABLE. With the feature, a separate timeout counter runs here; on expiry go to REINIT.
  - STABLE: decrement while lock_s=1; when counter hits 0, go to REL_MEM.
  - REL_MEM: mem_resetn=1; counter = MEM_TO_SYS_CYCLES-1, counts down; at 0, go to RUN.
  - RUN: sys_resetn=1, ready=1.
  - REINIT (feature only): pll_reinit=1 for REINIT_PULSE cycles, then back to WAIT_LOCK with the timeout reloaded.
- lock_s=0 in STABLE, REL_MEM or RUN: go to WAIT_LOCK next cycle and re-assert both resets that same cycle. This includes a glitch during debounce.
- lost_cnt increments only on the RUN→WAIT_LOCK transition. It saturates at 255 and is cleared only by resetn.
- resetn low, including mid-sequence: every state jumps to WAIT_LOCK and all counters clear.

## Timing
- Reset values: mem_resetn=0, sys_resetn=0, ready=0, lost_cnt=0, pll_reinit=0, synchroniser flops=0.
- All outputs are registered; no combinational path from input to output.
- Lock latency: pll_lock rises in cycle T, so lock_s=1 at T+2.
- mem_resetn rises at T+2+STABLE_CYCLES+1.
- sys_resetn and ready rise MEM_TO_SYS_CYCLES cycles after mem_resetn.
- Lock loss: lock_s falls in cycle L, so mem_resetn, sys_resetn and ready are 0 at L+1.
- Simultaneous lock loss and counter expiry: lock loss wins.
- REINIT: pll_lock is ignored for the whole pulse. The debounce restarts only after returning to WAIT_LOCK.

## Configuration
- PLL_RESET_SEQ_RELOCK_EN defined: the LOCK_TIMEOUT watchdog and the REINIT state are compiled in. pll_reinit pulses as specified.
- Not defined: there is no timeout counter and no REINIT state. WAIT_LOCK waits indefinitely, and pll_reinit is tied 0.

## Test plan
- Clean lock: STABLE_CYCLES=8, MEM_TO_SYS_CYCLES=4; pll_lock rises at cycle 10 and stays high. Required: mem_resetn=1 at cycle 21, sys_resetn=1 and ready=1 at cycle 25, lost_cnt=0.
- Debounce glitch: pll_lock high 5 cycles, low 1 cycle, then high. Required: mem_resetn stays 0 until 8 consecutive lock_s-high cycles after the glitch.
- Loss in RUN: drop pll_lock for 3 cycles while in RUN. Required: both resets are 0 one cycle after lock_s falls, lost_cnt=1, then the full sequence repeats. Repeat 300 times; required: lost_cnt=255.
- Reset mid-sequence: pulse resetn low for 1 cycle during REL_MEM. Required: all outputs return to reset values, then the sequence restarts from WAIT_LOCK.
- Watchdog (macro defined): LOCK_TIMEOUT=20, REINIT_PULSE=4, pll_lock held 0. Required: pll_reinit high for 4 cycles every 24 cycles. With the macro undefined, pll_reinit stays 0.
